rtc_calendar: RTL and testbench

RTC_CALENDAR -- requirements
Module: rtc_calendar

---
 rtl/rtc_calendar_pkg.sv | 56 +++++
 rtl/rtc_calendar_if.sv | 48 ++++
 rtl/rtc_calendar_prescaler.sv | 44 ++++
 rtl/rtc_calendar.sv | 216 +++++++++++++++++++++
 tb/tb_rtc_calendar.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_calendar_pkg.sv
// rtc_pkg: shared definitions for the RTC calendar block.
//   - calendar field widths
//   - week-day encoding (MON=1 .. SUN=7)
//   - power-on / reset time defaults
//   - FSM state type
//   - is_leap() and days_in_month() calendar helpers
package rtc_pkg;

    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int WEEK_W  = 3;

    typedef enum logic [WEEK_W-1:0] {
        MON = 3'd1,
        TUE = 3'd2,
        WED = 3'd3,
        THU = 3'd4,
        FRI = 3'd5,
        SAT = 3'd6,
        SUN = 3'd7
    } week_e;

    // 2000-01-01 00:00:00 was a Saturday.
    localparam int unsigned        RST_YEAR  = 2000;
    localparam logic [MONTH_W-1:0] RST_MONTH = 4'd1;
    localparam logic [DAY_W-1:0]   RST_DAY   = 5'd1;
    localparam logic [HOUR_W-1:0]  RST_HOUR  = 5'd0;
    localparam logic [MIN_W-1:0]   RST_MIN   = 6'd0;
    localparam logic [SEC_W-1:0]   RST_SEC   = 6'd0;
    localparam logic [WEEK_W-1:0]  RST_WEEK  = SAT;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } rtc_state_e;

    function automatic logic is_leap(input int unsigned year);
        return ((year % 4) == 0) && (((year % 100) != 0) || ((year % 400) == 0));
    endfunction

    // Months outside 1..12 report 31; callers range-check the month separately.
    function automatic logic [DAY_W-1:0] days_in_month(input int unsigned year,
                                                       input logic [MONTH_W-1:0] month);
        logic [DAY_W-1:0] days;
        case (month)
            4'd2:                     days = is_leap(year) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:  days = 5'd30;
            default:                  days = 5'd31;
        endcase
        return days;
    endfunction

endpackage

// File: rtl/rtc_calendar_if.sv
// rtc_calendar_if: run control, set-time handshake and time outputs of the RTC.
//   slave  (RTC side)  : in  run, ld_valid, ld_* fields
//                        out ld_ready, ld_err, year..week, hour12, pm, *_p pulses
//   master (host side) : mirror image of slave
interface rtc_calendar_if #(
    parameter int YEAR_W = 16
);
    import rtc_pkg::*;

    logic                run;
    logic                ld_valid;
    logic                ld_ready;
    logic [YEAR_W-1:0]   ld_year;
    logic [MONTH_W-1:0]  ld_month;
    logic [DAY_W-1:0]    ld_day;
    logic [HOUR_W-1:0]   ld_hour;
    logic [MIN_W-1:0]    ld_min;
    logic [SEC_W-1:0]    ld_sec;
    logic [WEEK_W-1:0]   ld_week;
    logic                ld_err;

    logic [YEAR_W-1:0]   year;
    logic [MONTH_W-1:0]  month;
    logic [DAY_W-1:0]    day;
    logic [HOUR_W-1:0]   hour;
    logic [MIN_W-1:0]    minute;
    logic [SEC_W-1:0]    second;
    logic [WEEK_W-1:0]   week;
    logic [3:0]          hour12;
    logic                pm;
    logic                sec_p;
    logic                min_p;
    logic                hour_p;
    logic                day_p;

    modport slave (
        input  run, ld_valid, ld_year, ld_month, ld_day, ld_hour, ld_min, ld_sec, ld_week,
        output ld_ready, ld_err, year, month, day, hour, minute, second, week,
               hour12, pm, sec_p, min_p, hour_p, day_p
    );

    modport master (
        output run, ld_valid, ld_year, ld_month, ld_day, ld_hour, ld_min, ld_sec, ld_week,
        input  ld_ready, ld_err, year, month, day, hour, minute, second, week,
               hour12, pm, sec_p, min_p, hour_p, day_p
    );

endinterface

// File: rtl/rtc_calendar_prescaler.sv
// rtc_prescaler: divides clk by DIV. Counts 0..DIV-1 while en is high and
// registers a one-cycle tick on the wrap. clr returns the count to 0 and
// drops a tick that is in flight.
//   clk, rst : clock, async active-high reset
//   en       : count enable (count freezes when low)
//   clr      : synchronous clear
//   tick     : one-cycle pulse, the cycle after the count wraps
module rtc_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          tick_q;
    logic          wrap;

    assign wrap = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (clr) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (en) begin
            cnt_q  <= wrap ? '0 : cnt_q + 1'b1;
            tick_q <= wrap;
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/rtc_calendar.sv
// rtc_calendar: real-time clock / calendar with a validated set-time port.
//   clk, rst : clock, async active-high reset
//   bus      : rtc_calendar_if.slave (run, ld_* handshake, time outputs, pulses)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ld_ready=1, prescaler runs, ticks (and a pending tick) applied
//   CHECK | one cycle: captured load validated, then committed or rejected
module rtc_calendar
    import rtc_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int YEAR_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    rtc_calendar_if.slave  bus
);

    localparam int DIV = (TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 0;
    localparam int REM = (TICK_HZ > 0) ? CLK_HZ % TICK_HZ : 1;

    generate
        if (DIV < 1 || REM != 0) begin : g_bad_div
            $error("rtc_calendar: CLK_HZ/TICK_HZ must be an integer >= 1");
        end
    endgenerate

    rtc_state_e          state_q;
    logic                ld_ready_q, ld_err_q, pend_q;
    logic [YEAR_W-1:0]   year_q,  cap_year_q;
    logic [MONTH_W-1:0]  month_q, cap_month_q;
    logic [DAY_W-1:0]    day_q,   cap_day_q;
    logic [HOUR_W-1:0]   hour_q,  cap_hour_q;
    logic [MIN_W-1:0]    min_q,   cap_min_q;
    logic [SEC_W-1:0]    sec_q,   cap_sec_q;
    logic [WEEK_W-1:0]   week_q,  cap_week_q;
    logic                sec_p_q, min_p_q, hour_p_q, day_p_q;

    logic [YEAR_W-1:0]   year_d;
    logic [MONTH_W-1:0]  month_d;
    logic [DAY_W-1:0]    day_d;
    logic [HOUR_W-1:0]   hour_d;
    logic [MIN_W-1:0]    min_d;
    logic [SEC_W-1:0]    sec_d;
    logic [WEEK_W-1:0]   week_d;
    logic                roll_sec, roll_min, roll_hour;

    logic tick, hs, apply, cap_ok;
    logic [3:0] hour_mod;

    rtc_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.run && (state_q == ST_IDLE)),
        .clr  ((state_q == ST_CHECK) && cap_ok),
        .tick (tick)
    );

    assign hs    = (state_q == ST_IDLE) && bus.ld_valid && ld_ready_q;
    assign apply = (state_q == ST_IDLE) && (tick || pend_q);

    // One-second advance of the current time with the full carry chain.
    always_comb begin
        year_d    = year_q;
        month_d   = month_q;
        day_d     = day_q;
        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q + 6'd1;
        week_d    = week_q;
        roll_sec  = 1'b0;
        roll_min  = 1'b0;
        roll_hour = 1'b0;
        if (sec_q == 6'd59) begin
            sec_d    = '0;
            roll_sec = 1'b1;
            min_d    = min_q + 6'd1;
            if (min_q == 6'd59) begin
                min_d    = '0;
                roll_min = 1'b1;
                hour_d   = hour_q + 5'd1;
                if (hour_q == 5'd23) begin
                    hour_d    = '0;
                    roll_hour = 1'b1;
                    week_d    = (week_q == SUN) ? MON : week_q + 3'd1;
                    day_d     = day_q + 5'd1;
                    if (day_q == days_in_month(32'(year_q), month_q)) begin
                        day_d   = 5'd1;
                        month_d = month_q + 4'd1;
                        if (month_q == 4'd12) begin
                            month_d = 4'd1;
                            year_d  = year_q + 1'b1;   // wraps at 2^YEAR_W-1
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        cap_ok = (cap_month_q >= 4'd1) && (cap_month_q <= 4'd12) &&
                 (cap_day_q >= 5'd1) &&
                 (cap_day_q <= days_in_month(32'(cap_year_q), cap_month_q)) &&
                 (cap_hour_q <= 5'd23) && (cap_min_q <= 6'd59) &&
                 (cap_sec_q <= 6'd59) && (cap_week_q != 3'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ld_ready_q  <= 1'b0;
            ld_err_q    <= 1'b0;
            pend_q      <= 1'b0;
            year_q      <= YEAR_W'(RST_YEAR);
            month_q     <= RST_MONTH;
            day_q       <= RST_DAY;
            hour_q      <= RST_HOUR;
            min_q       <= RST_MIN;
            sec_q       <= RST_SEC;
            week_q      <= RST_WEEK;
            cap_year_q  <= '0;
            cap_month_q <= '0;
            cap_day_q   <= '0;
            cap_hour_q  <= '0;
            cap_min_q   <= '0;
            cap_sec_q   <= '0;
            cap_week_q  <= '0;
            sec_p_q     <= 1'b0;
            min_p_q     <= 1'b0;
            hour_p_q    <= 1'b0;
            day_p_q     <= 1'b0;
        end else begin
            sec_p_q  <= 1'b0;
            min_p_q  <= 1'b0;
            hour_p_q <= 1'b0;
            day_p_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A tick and a handshake may share this cycle: the tick is
                    // applied here and the later commit overwrites it.
                    if (apply) begin
                        year_q   <= year_d;
                        month_q  <= month_d;
                        day_q    <= day_d;
                        hour_q   <= hour_d;
                        min_q    <= min_d;
                        sec_q    <= sec_d;
                        week_q   <= week_d;
                        pend_q   <= 1'b0;
                        // Each pulse marks the unit that just advanced.
                        sec_p_q  <= 1'b1;
                        min_p_q  <= roll_sec;
                        hour_p_q <= roll_min;
                        day_p_q  <= roll_hour;
                    end
                    if (hs) begin
                        cap_year_q  <= bus.ld_year;
                        cap_month_q <= bus.ld_month;
                        cap_day_q   <= bus.ld_day;
                        cap_hour_q  <= bus.ld_hour;
                        cap_min_q   <= bus.ld_min;
                        cap_sec_q   <= bus.ld_sec;
                        cap_week_q  <= bus.ld_week;
                        state_q     <= ST_CHECK;
                        ld_ready_q  <= 1'b0;
                    end else begin
                        ld_ready_q  <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    state_q    <= ST_IDLE;
                    ld_ready_q <= 1'b1;
                    if (cap_ok) begin
                        year_q   <= cap_year_q;
                        month_q  <= cap_month_q;
                        day_q    <= cap_day_q;
                        hour_q   <= cap_hour_q;
                        min_q    <= cap_min_q;
                        sec_q    <= cap_sec_q;
                        week_q   <= cap_week_q;
                        ld_err_q <= 1'b0;
                        pend_q   <= 1'b0;
                    end else begin
                        ld_err_q <= 1'b1;
                        pend_q   <= tick;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    ld_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign hour_mod = 4'((hour_q >= 5'd12) ? hour_q - 5'd12 : hour_q);

    assign bus.ld_ready = ld_ready_q;
    assign bus.ld_err   = ld_err_q;
    assign bus.year     = year_q;
    assign bus.month    = month_q;
    assign bus.day      = day_q;
    assign bus.hour     = hour_q;
    assign bus.minute   = min_q;
    assign bus.second   = sec_q;
    assign bus.week     = week_q;
    assign bus.hour12   = (hour_mod == 4'd0) ? 4'd12 : hour_mod;
    assign bus.pm       = (hour_q >= 5'd12);
    assign bus.sec_p    = sec_p_q;
    assign bus.min_p    = min_p_q;
    assign bus.hour_p   = hour_p_q;
    assign bus.day_p    = day_p_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed bench for rtc_calendar at CLK_HZ=4, TICK_HZ=1 (one tick per 4 clocks).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_rtc_calendar;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rtc_calendar_if #(.YEAR_W(16)) bus ();

    rtc_calendar #(.CLK_HZ(4), .TICK_HZ(1), .YEAR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] tm(input int y, input int mo, input int d, input int h,
                                       input int mi, input int s, input int w);
        return {19'd0, 16'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s), 3'(w)};
    endfunction

    function automatic logic [63:0] now();
        return {19'd0, bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.second, bus.week};
    endfunction

    function automatic logic [3:0] pls();
        return {bus.sec_p, bus.min_p, bus.hour_p, bus.day_p};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input int y, input int mo, input int d, input int h,
                          input int mi, input int s, input int w);
        bus.ld_year  = 16'(y);
        bus.ld_month = 4'(mo);
        bus.ld_day   = 5'(d);
        bus.ld_hour  = 5'(h);
        bus.ld_min   = 6'(mi);
        bus.ld_sec   = 6'(s);
        bus.ld_week  = 3'(w);
    endtask

    // Handshake on the next edge, validation/commit on the one after.
    task automatic load(input int y, input int mo, input int d, input int h,
                        input int mi, input int s, input int w);
        set_ld(y, mo, d, h, mi, s, w);
        bus.ld_valid = 1'b1;
        step(1);
        chk("check_ready_low", bus.ld_ready, 0);
        bus.ld_valid = 1'b0;
        step(1);
    endtask

    // Run until exactly one tick has been applied after a fresh commit.
    task automatic adv1(input string tag, input logic [63:0] exp_t, input logic [3:0] exp_p);
        bus.run = 1'b1;
        step(5);
        chk(tag, now(), exp_t);
        chk({tag, "_pulses"}, pls(), exp_p);
        bus.run = 1'b0;
    endtask

    initial begin
        bus.run      = 1'b0;
        bus.ld_valid = 1'b0;
        set_ld(0, 0, 0, 0, 0, 0, 0);

        // Reset values while rst is held
        #1 rst = 1'b1;
        #2;
        chk("rst_time", now(), tm(2000, 1, 1, 0, 0, 0, 6));
        chk("rst_ready", bus.ld_ready, 0);
        chk("rst_err", bus.ld_err, 0);
        chk("rst_pulses", pls(), 4'b0000);
        chk("rst_hour12", bus.hour12, 12);
        chk("rst_pm", bus.pm, 0);
        step(2);
        chk("rst_ready_held", bus.ld_ready, 0);

        // Release with run=1: tick after 4 edges, time advances on the 5th
        bus.run = 1'b1;
        #3 rst = 1'b0;
        step(1);
        chk("rel_ready", bus.ld_ready, 1);
        step(3);
        chk("rel_pre_tick", now(), tm(2000, 1, 1, 0, 0, 0, 6));
        step(1);
        chk("rel_first_tick", now(), tm(2000, 1, 1, 0, 0, 1, 6));
        chk("rel_sec_p", pls(), 4'b1000);
        step(1);
        chk("rel_sec_p_one_cycle", pls(), 4'b0000);
        bus.run = 1'b0;

        // New year rollover
        load(2023, 12, 31, 23, 59, 58, 7);
        chk("ny_commit", now(), tm(2023, 12, 31, 23, 59, 58, 7));
        chk("ny_commit_pulses", pls(), 4'b0000);
        chk("ny_commit_err", bus.ld_err, 0);
        chk("ny_commit_ready", bus.ld_ready, 1);
        bus.run = 1'b1;
        step(4);
        chk("ny_wait", now(), tm(2023, 12, 31, 23, 59, 58, 7));
        step(1);
        chk("ny_59", now(), tm(2023, 12, 31, 23, 59, 59, 7));
        chk("ny_59_pulses", pls(), 4'b1000);
        step(4);
        chk("ny_roll", now(), tm(2024, 1, 1, 0, 0, 0, 1));
        chk("ny_roll_pulses", pls(), 4'b1111);
        chk("ny_hour12", bus.hour12, 12);
        chk("ny_pm", bus.pm, 0);
        step(1);
        chk("ny_pulses_clear", pls(), 4'b0000);
        bus.run = 1'b0;

        // Leap-year and month-end boundaries
        load(2024, 2, 28, 23, 59, 59, 3);
        chk("h23_hour12", bus.hour12, 11);
        chk("h23_pm", bus.pm, 1);
        adv1("leap_2024", tm(2024, 2, 29, 0, 0, 0, 4), 4'b1111);
        load(2100, 2, 28, 23, 59, 59, 7);
        adv1("noleap_2100", tm(2100, 3, 1, 0, 0, 0, 1), 4'b1111);
        load(2000, 2, 28, 23, 59, 59, 1);
        adv1("leap_2000", tm(2000, 2, 29, 0, 0, 0, 2), 4'b1111);
        load(2023, 6, 30, 23, 59, 59, 5);
        adv1("june_end", tm(2023, 7, 1, 0, 0, 0, 6), 4'b1111);
        load(2023, 6, 15, 11, 59, 59, 4);
        chk("h11_pm", bus.pm, 0);
        adv1("noon", tm(2023, 6, 15, 12, 0, 0, 4), 4'b1110);
        chk("noon_hour12", bus.hour12, 12);
        chk("noon_pm", bus.pm, 1);

        // run=0 freezes the prescaler mid-count
        load(2023, 3, 10, 8, 30, 15, 5);
        chk("h8_hour12", bus.hour12, 8);
        bus.run = 1'b1;
        step(2);
        bus.run = 1'b0;
        step(20);
        chk("freeze_time", now(), tm(2023, 3, 10, 8, 30, 15, 5));
        bus.run = 1'b1;
        step(2);
        chk("freeze_resume_wait", now(), tm(2023, 3, 10, 8, 30, 15, 5));
        step(1);
        chk("freeze_resume_tick", now(), tm(2023, 3, 10, 8, 30, 16, 5));
        bus.run = 1'b0;

        // Rejected loads leave time alone and set ld_err; a good one clears it
        load(2023, 4, 31, 10, 0, 0, 1);
        chk("apr31_time", now(), tm(2023, 3, 10, 8, 30, 16, 5));
        chk("apr31_err", bus.ld_err, 1);
        chk("apr31_pulses", pls(), 4'b0000);
        load(2023, 4, 30, 24, 0, 0, 1);
        chk("hour24_time", now(), tm(2023, 3, 10, 8, 30, 16, 5));
        load(2023, 4, 30, 10, 0, 0, 0);
        chk("week0_err", bus.ld_err, 1);
        load(2023, 4, 30, 10, 0, 0, 7);
        chk("apr30_time", now(), tm(2023, 4, 30, 10, 0, 0, 7));
        chk("apr30_err", bus.ld_err, 0);

        // Tick and handshake in the same IDLE cycle
        load(2023, 5, 5, 5, 5, 5, 5);
        bus.run = 1'b1;
        step(4);
        set_ld(2023, 5, 6, 6, 6, 6, 6);
        bus.ld_valid = 1'b1;
        bus.run = 1'b0;
        step(1);
        chk("same_cycle_tick", now(), tm(2023, 5, 5, 5, 5, 6, 5));
        chk("same_cycle_pulses", pls(), 4'b1000);
        bus.ld_valid = 1'b0;
        step(1);
        chk("same_cycle_commit", now(), tm(2023, 5, 6, 6, 6, 6, 6));
        chk("commit_no_pulse", pls(), 4'b0000);

        // ld_valid held high: capture every 2 cycles, tick landing in CHECK
        load(2023, 8, 1, 7, 0, 0, 2);
        set_ld(2023, 13, 1, 0, 0, 0, 1);
        bus.ld_valid = 1'b1;
        bus.run = 1'b1;
        step(1);
        chk("hold_ready_0", bus.ld_ready, 0);
        step(1);
        chk("hold_ready_1", bus.ld_ready, 1);
        chk("hold_err", bus.ld_err, 1);
        chk("hold_time", now(), tm(2023, 8, 1, 7, 0, 0, 2));
        step(1);
        chk("hold_ready_0b", bus.ld_ready, 0);
        step(5);
        chk("hold_pend_wait", now(), tm(2023, 8, 1, 7, 0, 0, 2));
        step(1);
        chk("hold_pend_applied", now(), tm(2023, 8, 1, 7, 0, 1, 2));
        chk("hold_pend_pulse", pls(), 4'b1000);
        step(5);
        chk("hold_steady", now(), tm(2023, 8, 1, 7, 0, 1, 2));
        set_ld(2023, 9, 9, 9, 9, 9, 3);
        step(2);
        chk("hold_commit", now(), tm(2023, 9, 9, 9, 9, 9, 3));
        chk("hold_commit_err", bus.ld_err, 0);
        bus.ld_valid = 1'b0;
        bus.run = 1'b0;
        step(2);
        chk("hold_tick_dropped", now(), tm(2023, 9, 9, 9, 9, 9, 3));

        // Async reset in CHECK and mid-prescale
        load(2023, 0, 1, 0, 0, 0, 1);
        chk("pre_rst_err", bus.ld_err, 1);
        bus.run = 1'b1;
        step(2);
        set_ld(2030, 1, 1, 1, 1, 1, 1);
        bus.ld_valid = 1'b1;
        step(1);
        #2 rst = 1'b1;
        #1;
        chk("arst_time", now(), tm(2000, 1, 1, 0, 0, 0, 6));
        chk("arst_ready", bus.ld_ready, 0);
        chk("arst_err", bus.ld_err, 0);
        bus.ld_valid = 1'b0;
        step(2);
        #3 rst = 1'b0;
        step(1);
        chk("arst_rel_ready", bus.ld_ready, 1);
        chk("arst_load_dropped", now(), tm(2000, 1, 1, 0, 0, 0, 6));
        step(3);
        chk("arst_pre_tick", now(), tm(2000, 1, 1, 0, 0, 0, 6));
        step(1);
        chk("arst_first_tick", now(), tm(2000, 1, 1, 0, 0, 1, 6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
